// File: rtl/bcd_adder16_reg.sv
// Registered packed-BCD adder Z = X + Y + cin with a per-digit decimal carry vector.
// One-cycle latency, one result per in_valid cycle; no backpressure, inputs always accepted.
module bcd_adder16_reg #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   X,
    input  logic [4*DIGITS-1:0]   Y,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   Z,
    output logic [DIGITS-1:0]     Cout,
    output logic                  err
);

    logic [4*DIGITS-1:0] w_z;
    logic [DIGITS-1:0]   w_cout;
    logic                w_err;
    logic                w_c;
    logic [3:0]          w_xd;
    logic [3:0]          w_yd;
    logic [4:0]          w_s;
    logic [4:0]          w_adj;

    logic [4*DIGITS-1:0] r_z;
    logic [DIGITS-1:0]   r_cout;
    logic                r_err;
    logic                r_vld;

    // Ripple kept inside one process so the carry chain is a plain sequential walk.
    always_comb begin
        w_z    = '0;
        w_cout = '0;
        w_err  = 1'b0;
        w_c    = cin;
        w_xd   = '0;
        w_yd   = '0;
        w_s    = '0;
        w_adj  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_xd  = X[4*i +: 4];
            w_yd  = Y[4*i +: 4];
            w_s   = {1'b0, w_xd} + {1'b0, w_yd} + {4'b0000, w_c};
            w_adj = w_s + 5'd6;
            if (w_s >= 5'd10) begin
                w_z[4*i +: 4] = w_adj[3:0];
                w_c           = 1'b1;
            end else begin
                w_z[4*i +: 4] = w_s[3:0];
                w_c           = 1'b0;
            end
            w_cout[i] = w_c;
            if ((w_xd > 4'd9) || (w_yd > 4'd9)) begin
                w_err = 1'b1;
            end
        end
    end

    // Result registers hold their value across idle cycles; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z    <= '0;
            r_cout <= '0;
            r_err  <= 1'b0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_z    <= w_z;
                r_cout <= w_cout;
                r_err  <= w_err;
            end
        end
    end

    assign Z         = r_z;
    assign Cout      = r_cout;
    assign err       = r_err;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_bcd_adder16_reg.sv
// Directed and reference-model checks for bcd_adder16_reg.
module tb_bcd_adder16_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        cin;
    logic [15:0] X;
    logic [15:0] Y;
    logic        out_valid;
    logic [15:0] Z;
    logic [3:0]  Cout;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_adder16_reg #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .cin       (cin),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .Z         (Z),
        .Cout      (Cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic c);
        X        = x;
        Y        = y;
        cin      = c;
        in_valid = 1'b1;
    endtask

    task automatic expect_res(input string tag, input logic [15:0] z,
                              input logic [3:0] co, input logic e);
        chk({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
        chk({tag, "_z"},    {16'd0, Z},         {16'd0, z});
        chk({tag, "_cout"}, {28'd0, Cout},      {28'd0, co});
        chk({tag, "_err"},  {31'd0, err},       {31'd0, e});
    endtask

    // Apply one operand pair for a single cycle and check the result one cycle later.
    task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic [15:0] z, input logic [3:0] co,
                          input logic e);
        @(negedge clk);
        drive(x, y, c);
        @(negedge clk);
        in_valid = 1'b0;
        expect_res(tag, z, co, e);
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    logic [15:0] tv_x [4];
    logic [15:0] tv_y [4];
    logic        tv_c [4];
    logic [15:0] tv_z [4];
    logic [3:0]  tv_co[4];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cin      = 1'b0;
        X        = '0;
        Y        = '0;
        #12;
        chk("rst_vld",  {31'd0, out_valid}, 32'd0);
        chk("rst_z",    {16'd0, Z},         32'd0);
        chk("rst_cout", {28'd0, Cout},      32'd0);
        chk("rst_err",  {31'd0, err},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single("nocarry", 16'h0200, 16'h0180, 1'b0, 16'h0380, 4'b0000, 1'b0);
        @(negedge clk);
        chk("idle_vld", {31'd0, out_valid}, 32'd0);
        chk("idle_z",   {16'd0, Z},         32'h0380);

        single("ripple", 16'h0550, 16'h0550, 1'b0, 16'h1100, 4'b0110, 1'b0);

        // Reset asserted mid-cycle with 0x1100 held must clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld",  {31'd0, out_valid}, 32'd0);
        chk("midrst_z",    {16'd0, Z},         32'd0);
        chk("midrst_cout", {28'd0, Cout},      32'd0);
        chk("midrst_err",  {31'd0, err},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_vld", {31'd0, out_valid}, 32'd0);
        chk("postrst_z",   {16'd0, Z},         32'd0);

        single("ripple2", 16'h0010, 16'h0205, 1'b1, 16'h0216, 4'b0000, 1'b0);
        single("wrap",    16'h9999, 16'h0001, 1'b0, 16'h0000, 4'b1111, 1'b0);
        single("max",     16'h9999, 16'h9999, 1'b1, 16'h9999, 4'b1111, 1'b0);
        single("bad",     16'h000A, 16'h0000, 1'b0, 16'h0010, 4'b0001, 1'b1);
        single("clrerr",  16'h0001, 16'h0002, 1'b0, 16'h0003, 4'b0000, 1'b0);

        tv_x[0] = 16'h1234; tv_y[0] = 16'h4321; tv_c[0] = 1'b0; tv_z[0] = 16'h5555; tv_co[0] = 4'b0000;
        tv_x[1] = 16'h0009; tv_y[1] = 16'h0001; tv_c[1] = 1'b0; tv_z[1] = 16'h0010; tv_co[1] = 4'b0001;
        tv_x[2] = 16'h0099; tv_y[2] = 16'h0001; tv_c[2] = 1'b1; tv_z[2] = 16'h0101; tv_co[2] = 4'b0011;
        tv_x[3] = 16'h5000; tv_y[3] = 16'h5000; tv_c[3] = 1'b0; tv_z[3] = 16'h0000; tv_co[3] = 4'b1000;
        @(negedge clk);
        drive(tv_x[0], tv_y[0], tv_c[0]);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            expect_res("thru", tv_z[k-1], tv_co[k-1], 1'b0);
            drive(tv_x[k], tv_y[k], tv_c[k]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        expect_res("thru", tv_z[3], tv_co[3], 1'b0);

        // Decimal reference: per-digit carry derived from prefix sums of the integer values.
        for (int n = 0; n < 10000; n++) begin
            logic [15:0] rx, ry, ez;
            logic        rc;
            logic [3:0]  eco;
            int          p;
            rx = rand_bcd();
            ry = rand_bcd();
            rc = 1'($urandom_range(0, 1));
            ez = int2bcd((bcd2int(rx) + bcd2int(ry) + int'(rc)) % 10000);
            p  = 1;
            for (int d = 0; d < 4; d++) begin
                p = p * 10;
                eco[d] = ((bcd2int(rx) % p) + (bcd2int(ry) % p) + int'(rc)) >= p;
            end
            @(negedge clk);
            drive(rx, ry, rc);
            @(negedge clk);
            in_valid = 1'b0;
            chk("rand_z",    {16'd0, Z},    {16'd0, ez});
            chk("rand_cout", {28'd0, Cout}, {28'd0, eco});
            chk("rand_err",  {31'd0, err},  32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_adder16_reg.md
Name: bcd_adder16_reg

Overview:
- Registered 4-digit packed-BCD adder: Z = X + Y + cin, decimal, with a per-digit carry vector.
- Serves as the arithmetic core behind the button/score front-end. That front-end supplies a constant X operand and a user Y operand, and displays Z.
- One clock, single-cycle latency, valid-qualified input and output.

Parameters:
- DIGITS, 4, number of BCD digits; data width = 4*DIGITS. Only 4 is verified.

Ports:
- clk        input   1   rising-edge clock
- rst_n      input   1   asynchronous active-low reset
- in_valid   input   1   operands valid this cycle; capture and add
- cin        input   1   decimal carry into digit 0
- X          input   16  operand A, packed BCD, digit 0 = X[3:0]
- Y          input   16  operand B, packed BCD
- out_valid  output  1   Z/Cout/err hold a result produced from the previous in_valid cycle
- Z          output  16  packed BCD sum, modulo 10^4
- Cout       output  4   Cout[i] = decimal carry out of digit i; Cout[3] = overall carry
- err        output  1   at least one operand nibble of the captured inputs was > 9

Behaviour:
- Reset (rst_n=0, asynchronous): Z=0x0000, Cout=4'b0000, err=0, out_valid=0 immediately. All stay held until the first post-reset in_valid edge.
- Per-digit combinational rule, i = 0..3, ripple c0 = cin:
  - s_i = X_i + Y_i + c_i, 5-bit
  - if s_i >= 10: digit_i = (s_i + 6)[3:0], carry c_{i+1} = 1
  - else: digit_i = s_i[3:0], carry c_{i+1} = 0
  - Cout[i] = c_{i+1}
- Registering:
  - On a rising clk edge with in_valid=1, Z, Cout and err are loaded from the combinational result, and out_valid goes to 1.
  - On an edge with in_valid=0, out_valid goes to 0. Z/Cout/err keep their last values; no bubble-zeroing.
- Latency: exactly 1 cycle. Back-to-back in_valid gives one result per cycle with no stall. No ready/backpressure.
- Overflow: 9999+0001 wraps to Z=0x0000 with Cout=4'b1111. The caller detects overflow via Cout[3].
- Invalid digits (nibble 0xA–0xF):
  - The same arithmetic rule is applied and result bits are truncated to 4 bits per digit; carry is 1 whenever s_i >= 10.
  - err=1 for that result. Z content is defined by the rule, but is not meaningful BCD.
- Max digit sum 9+9+1=19 gives digit 9, carry 1. All valid inputs yield valid BCD outputs.
- Reset asserted mid-stream: outputs clear asynchronously. The in-flight result is discarded. First result after deassertion needs a new in_valid.
- X/Y/cin are sampled only at the clock edge; glitches between edges have no effect.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with a prior result 0x1100 held -> Z=0x0000, Cout=0, err=0, out_valid=0 before the next edge.
- No carry: X=0x0200, Y=0x0180, cin=0, one in_valid pulse -> next cycle Z=0x0380, Cout=4'b0000, out_valid=1. The following cycle out_valid=0 and Z holds 0x0380.
- Ripple carry: X=0x0550, Y=0x0550 -> Z=0x1100, Cout=4'b0110. Then X=0x0010, Y=0x0205, cin=1 -> Z=0x0216, Cout=0.
- Wrap: X=0x9999, Y=0x0001 -> Z=0x0000, Cout=4'b1111. Also X=0x9999, Y=0x9999, cin=1 -> Z=0x9999, Cout=4'b1111.
- Invalid digit: X=0x000A, Y=0x0000 -> Z=0x0010, Cout=4'b0001, err=1. The next valid pair clears err to 0.
- Throughput: 4 consecutive in_valid cycles with distinct operands -> 4 consecutive correct results, each one cycle after its input. Compare against a decimal reference model over 10k random valid-BCD pairs plus random cin.
